// File: rtl/alu_rs.sv
// Reservation station ahead of the combinational ALU: buffers dispatched ops, wakes pending operands
// from the CDB and issues the oldest ready entry into a registered ALU word (2 edges issue->alu_load).
// Backpressure: full station drops issue_ready; alu_ready=0 freezes the ALU word and stops selection.
module alu_rs #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 3,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_op,
    input  logic [2:0]        issue_funct3,
    input  logic              issue_funct7,
    input  logic              issue_src1_valid,
    input  logic [DATA_W-1:0] issue_src1_data,
    input  logic [TAG_W-1:0]  issue_src1_tag,
    input  logic              issue_src2_valid,
    input  logic [DATA_W-1:0] issue_src2_data,
    input  logic [TAG_W-1:0]  issue_src2_tag,
    input  logic [TAG_W-1:0]  issue_dest_tag,
    input  logic              cdb_req,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              alu_ready,
    output logic              alu_load,
    output logic [2:0]        alu_op,
    output logic [2:0]        alu_funct3,
    output logic              alu_funct7,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [TAG_W-1:0]  alu_tag
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic [2:0]        op;
        logic [2:0]        funct3;
        logic              funct7;
        logic              s1_vld;
        logic [DATA_W-1:0] s1_dat;
        logic [TAG_W-1:0]  s1_tag;
        logic              s2_vld;
        logic [DATA_W-1:0] s2_dat;
        logic [TAG_W-1:0]  s2_tag;
        logic [TAG_W-1:0]  dest_tag;
    } ent_t;

    ent_t                   ent_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] vld_q;
    // older_q[i][j] set means entry i was allocated before entry j
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];

    logic              alu_load_q;
    logic [2:0]        alu_op_q;
    logic [2:0]        alu_funct3_q;
    logic              alu_funct7_q;
    logic [DATA_W-1:0] alu_src1_q;
    logic [DATA_W-1:0] alu_src2_q;
    logic [TAG_W-1:0]  alu_tag_q;

    logic [NUM_ENTRIES-1:0] rdy_vec;
    logic [NUM_ENTRIES-1:0] sel_oh;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   sel_any;
    logic                   can_load;
    logic                   alloc_en;
    logic                   dest_pending;
    ent_t                   new_ent;

    assign issue_ready = ~&vld_q;
    assign alloc_en    = issue_valid && issue_ready && !flush;
    assign can_load    = !alu_load_q || alu_ready;
    assign sel_any     = |sel_oh;

    always_comb begin
        alloc_idx    = '0;
        sel_idx      = '0;
        rdy_vec      = '0;
        sel_oh       = '0;
        dest_pending = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!vld_q[i]) alloc_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rdy_vec[i] = vld_q[i] && ent_q[i].s1_vld && ent_q[i].s2_vld;
            if (vld_q[i] && ((!ent_q[i].s1_vld && ent_q[i].s1_tag == issue_dest_tag) ||
                             (!ent_q[i].s2_vld && ent_q[i].s2_tag == issue_dest_tag)))
                dest_pending = 1'b1;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_oh[i] = rdy_vec[i];
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (j != i && rdy_vec[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
    end

    // A broadcast in the issue cycle is captured directly so the operand is not missed
    always_comb begin
        new_ent          = '0;
        new_ent.op       = issue_op;
        new_ent.funct3   = issue_funct3;
        new_ent.funct7   = issue_funct7;
        new_ent.dest_tag = issue_dest_tag;
        new_ent.s1_tag   = issue_src1_tag;
        new_ent.s2_tag   = issue_src2_tag;
        new_ent.s1_vld   = issue_src1_valid || (cdb_req && cdb_tag == issue_src1_tag);
        new_ent.s2_vld   = issue_src2_valid || (cdb_req && cdb_tag == issue_src2_tag);
        new_ent.s1_dat   = issue_src1_valid ? issue_src1_data : cdb_data;
        new_ent.s2_dat   = issue_src2_valid ? issue_src2_data : cdb_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q        <= '0;
            alu_load_q   <= 1'b0;
            alu_op_q     <= '0;
            alu_funct3_q <= '0;
            alu_funct7_q <= 1'b0;
            alu_src1_q   <= '0;
            alu_src2_q   <= '0;
            alu_tag_q    <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q      <= '0;
            alu_load_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (vld_q[i] && cdb_req) begin
                    if (!ent_q[i].s1_vld && ent_q[i].s1_tag == cdb_tag) begin
                        ent_q[i].s1_vld <= 1'b1;
                        ent_q[i].s1_dat <= cdb_data;
                    end
                    if (!ent_q[i].s2_vld && ent_q[i].s2_tag == cdb_tag) begin
                        ent_q[i].s2_vld <= 1'b1;
                        ent_q[i].s2_dat <= cdb_data;
                    end
                end
            end
            if (can_load) begin
                alu_load_q <= sel_any;
                if (sel_any) begin
                    vld_q[sel_idx] <= 1'b0;
                    alu_op_q       <= ent_q[sel_idx].op;
                    alu_funct3_q   <= ent_q[sel_idx].funct3;
                    alu_funct7_q   <= ent_q[sel_idx].funct7;
                    alu_src1_q     <= ent_q[sel_idx].s1_dat;
                    alu_src2_q     <= ent_q[sel_idx].s2_dat;
                    alu_tag_q      <= ent_q[sel_idx].dest_tag;
                end
            end
            if (alloc_en) begin
                vld_q[alloc_idx] <= 1'b1;
                ent_q[alloc_idx] <= new_ent;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    older_q[alloc_idx][j] <= 1'b0;
                    if (j != int'(alloc_idx)) older_q[j][alloc_idx] <= 1'b1;
                end
            end
        end
    end

    assign alu_load   = alu_load_q;
    assign alu_op     = alu_op_q;
    assign alu_funct3 = alu_funct3_q;
    assign alu_funct7 = alu_funct7_q;
    assign alu_src1   = alu_src1_q;
    assign alu_src2   = alu_src2_q;
    assign alu_tag    = alu_tag_q;

    a_no_full_alloc: assert property (@(posedge clk) disable iff (!rst) !(alloc_en && &vld_q));
    a_dest_not_pending: assert property (@(posedge clk) disable iff (!rst) alloc_en |-> !dest_pending);
    a_no_x_out: assert property (@(posedge clk) disable iff (!rst)
        !$isunknown({alu_load, alu_op, alu_funct3, alu_funct7, alu_src1, alu_src2, alu_tag, issue_ready}));
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the combinational ALU; the ALU side is the receiver of the operand/command word and the source of CDB broadcasts.
- Accepts instructions from dispatch with operands either ready or pending on a tag.
- Snoops the CDB and wakes pending operands when their tags are broadcast.
- Selects the oldest fully-ready entry and presents a registered alu word (op, src1, src2, funct3, funct7, tag, load) to the ALU.

Parameters:
NUM_ENTRIES, 4, reservation station depth (power of 2, 2..16)
TAG_W, 3, width of ROB/CDB tag
DATA_W, 32, operand width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all entries and pending output
issue_valid  in  1  dispatch presents an instruction
issue_ready  out  1  station can accept an instruction this cycle
issue_op  in  3  tomasula op class (BRANCH/ARITH/AUIPC/JAL/JALR)
issue_funct3  in  3  funct3
issue_funct7  in  1  funct7 alternate bit
issue_src1_valid  in  1  src1 data is final
issue_src1_data  in  DATA_W  src1 value when valid
issue_src1_tag  in  TAG_W  producer tag when not valid
issue_src2_valid, issue_src2_data, issue_src2_tag  in  1/DATA_W/TAG_W  same for src2
issue_dest_tag  in  TAG_W  result tag
cdb_req  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_data  in  DATA_W  CDB broadcast value
alu_ready  in  1  ALU/CDB slot accepts the presented word
alu_load  out  1  alu word valid (drives ALU load/req)
alu_op  out  3  op class
alu_funct3  out  3
alu_funct7  out  1
alu_src1, alu_src2  out  DATA_W  operands
alu_tag  out  TAG_W  destination tag

Behaviour:
- Reset (rst low, async): all entry valid bits 0, age state cleared, alu_load=0, all alu_* data outputs 0, issue_ready=1.
- issue_ready=1 iff at least one entry is free at cycle start. Slots freed by this cycle's dispatch are not counted (no same-cycle reuse).
- Allocation: on issue_valid && issue_ready, write the lowest-index free entry at the edge and record it as youngest.
- Same-cycle bypass at issue: if an operand is not valid and cdb_req && cdb_tag equals its tag, store cdb_data and mark the operand valid.
- Wakeup: each valid entry with a pending operand whose tag matches cdb_tag while cdb_req=1 captures cdb_data at the edge.
  - Both operands can wake on the same broadcast.
  - A woken entry becomes eligible for selection the following cycle.
- Eligibility: entry valid and both operand-valid bits set at cycle start.
- Selection: oldest eligible entry by allocation order. Age is tracked exactly, so the select never depends on index.
- Output register:
  - If alu_load=0, or alu_load=1 && alu_ready=1: load the selected entry into the alu_* registers, set alu_load=1, and free the entry at the same edge.
  - If no entry is eligible in that case, set alu_load=0 and hold the data outputs.
  - If alu_load=1 && alu_ready=0: hold all alu_* outputs and do not select.
- Latency: an instruction issued with both operands valid appears on alu_load two edges after issue (allocate edge, select edge), assuming no older eligible entry and no stall.
- Full: issue_ready=0 with all entries valid. issue_valid is ignored and dispatch must hold its request.
- Simultaneous issue + dispatch + wakeup in one cycle: all three are legal and independent.
- flush (sync, highest priority over issue/dispatch): next edge clears all valid bits and alu_load=0. Incoming issue in the flush cycle is dropped.
- Asserting rst mid-operation discards all state immediately.
- Tags are compared at full TAG_W. Tag 0 has no special meaning.
- No X on outputs after reset.
- Assertions:
  - Two valid pending operands never hold the same tag as the issue dest_tag.
  - No allocation when full.

Test Plan:
- Reset, then issue ARITH add, src1=5, src2=7, both valid, tag=2, alu_ready=1 -> alu_load=1 two edges later with src1=5, src2=7, tag=2. Then alu_load=0.
- Issue entry with src1 pending tag=3. Three cycles later cdb_req=1, tag=3, data=0x1234 -> entry dispatches next edge with alu_src1=0x1234.
- Issue pending on tag=4 in the same cycle as cdb broadcast tag=4, data=9 -> bypass captured. Dispatch with src1=9 at issue+2.
- Fill 4 entries, pending, in order A,B,C,D. Wake D, then B, on one broadcast -> B dispatches before D. issue_ready=0 while full and 1 the cycle after the first dispatch.
- Hold alu_ready=0 for 3 cycles with alu_load=1 -> all alu_* outputs stable. The next eligible entry is presented only after the ready edge.
- Two entries valid, flush=1 for one cycle during an issue -> alu_load=0, issue_ready=1, no later dispatch.
- Assert rst low asynchronously mid-stream -> same state as at power-on.
